// File: rtl/game_keys_ctrl.sv
// Key conditioner: per-key synchroniser, debounce FSM, press/release/repeat strobes and a sticky press-event register.
// Optional auto-repeat is compiled in when GAME_KEYS_REPEAT_EN is defined.
module game_keys_ctrl #(
  parameter int unsigned KEYS_N    = 4,
  parameter bit          ACT_LVL   = 1'b1,
  parameter int unsigned DEB_CYC   = 50000,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned REP_DELAY = 25000,
  parameter int unsigned REP_RATE  = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [KEYS_N-1:0] keys,
  output logic [KEYS_N-1:0] key_level,
  output logic [KEYS_N-1:0] key_press,
  output logic [KEYS_N-1:0] key_release,
  output logic [KEYS_N-1:0] key_repeat,
  input  logic [KEYS_N-1:0] evt_clr,
  output logic [KEYS_N-1:0] evt_press,
  output logic              evt_any
);

  localparam bit CFG_OK = (DEB_CYC >= 2) && (REP_RATE >= 1) && (REP_DELAY >= REP_RATE) &&
                          (64'(DEB_CYC) < (64'(1) << CNT_W)) &&
                          (64'(REP_DELAY) < (64'(1) << CNT_W));

  if (!CFG_OK) begin : g_cfg_bad
    $error("game_keys_ctrl: inconsistent debounce/repeat parameters");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
`ifdef GAME_KEYS_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REP_DELAY - REP_RATE);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PCHK,
    ST_HELD,
    ST_RCHK
  } state_e;

  // Normalise to pressed = 1, then two-flop synchronise
  logic [KEYS_N-1:0] keys_norm;
  logic [KEYS_N-1:0] sync1_q;
  logic [KEYS_N-1:0] sync2_q;

  assign keys_norm = keys ^ {KEYS_N{~ACT_LVL}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= keys_norm;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < KEYS_N; g++) begin : g_key
    state_e           state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             ksync;

    assign ksync = sync2_q[g];

`ifdef GAME_KEYS_REPEAT_EN
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             repeat_q, repeat_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rcnt_q   <= '0;
        repeat_q <= 1'b0;
      end else begin
        rcnt_q   <= rcnt_d;
        repeat_q <= repeat_d;
      end
    end

    assign key_repeat[g] = repeat_q;
`else
    assign key_repeat[g] = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q   <= ST_IDLE;
        dcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        dcnt_q    <= dcnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Debounce FSM; rcnt only advances while held and stable, frozen in RCHK
    always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef GAME_KEYS_REPEAT_EN
      rcnt_d    = rcnt_q;
      repeat_d  = 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (ksync) begin
            state_d = ST_PCHK;
            dcnt_d  = '0;
          end
        end
        ST_PCHK: begin
          if (!ksync) begin
            state_d = ST_IDLE;
          end else if (dcnt_q == DEB_LAST) begin
            state_d = ST_HELD;
            level_d = 1'b1;
            press_d = 1'b1;
`ifdef GAME_KEYS_REPEAT_EN
            rcnt_d  = '0;
`endif
          end else begin
            dcnt_d = dcnt_q + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!ksync) begin
            state_d = ST_RCHK;
            dcnt_d  = '0;
          end
`ifdef GAME_KEYS_REPEAT_EN
          else if (rcnt_q == REP_LAST) begin
            repeat_d = 1'b1;
            rcnt_d   = REP_RELOAD;
          end else begin
            rcnt_d = rcnt_q + CNT_W'(1);
          end
`endif
        end
        ST_RCHK: begin
          if (ksync) begin
            state_d = ST_HELD;
          end else if (dcnt_q == DEB_LAST) begin
            state_d   = ST_IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
  end

  // Sticky press events, set from the registered strobe; set beats clear
  logic [KEYS_N-1:0] evt_d;
  logic [KEYS_N-1:0] evt_q;
  logic              evt_any_q;

  assign evt_d = (evt_q & ~evt_clr) | key_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_q     <= '0;
      evt_any_q <= 1'b0;
    end else begin
      evt_q     <= evt_d;
      evt_any_q <= |evt_d;
    end
  end

  assign evt_press = evt_q;
  assign evt_any   = evt_any_q;

endmodule

// File: tb/tb_game_keys_ctrl.sv
// Bench for game_keys_ctrl: active-high and active-low instances checked every cycle
// against a run-length reference model, plus directed latency/glitch/repeat/event steps.
module tb_game_keys_ctrl;

  localparam int unsigned DEB   = 4;
  localparam int unsigned RDLY  = 10;
  localparam int unsigned RRATE = 3;

  logic       clk;
  logic       rst;
  logic [3:0] keys_hi, keys_lo, clr_hi, clr_lo;
  logic [3:0] hi_lvl, hi_prs, hi_rel, hi_rep, hi_evt;
  logic [3:0] lo_lvl, lo_prs, lo_rel, lo_rep, lo_evt;
  logic       hi_any, lo_any;

  int tests = 0;
  int fails = 0;

  game_keys_ctrl #(.KEYS_N(4), .ACT_LVL(1'b1), .DEB_CYC(DEB), .CNT_W(8),
                   .REP_DELAY(RDLY), .REP_RATE(RRATE)) u_hi (
    .clk(clk), .reset(rst), .keys(keys_hi),
    .key_level(hi_lvl), .key_press(hi_prs), .key_release(hi_rel), .key_repeat(hi_rep),
    .evt_clr(clr_hi), .evt_press(hi_evt), .evt_any(hi_any));

  game_keys_ctrl #(.KEYS_N(4), .ACT_LVL(1'b0), .DEB_CYC(DEB), .CNT_W(8),
                   .REP_DELAY(RDLY), .REP_RATE(RRATE)) u_lo (
    .clk(clk), .reset(rst), .keys(keys_lo),
    .key_level(lo_lvl), .key_press(lo_prs), .key_release(lo_rel), .key_repeat(lo_rep),
    .evt_clr(clr_lo), .evt_press(lo_evt), .evt_any(lo_any));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: index 0 = active-high instance, 1 = active-low instance
  logic [3:0] sy1 [2];
  logic [3:0] sy2 [2];
  logic [3:0] e_lvl [2];
  logic [3:0] e_prs [2];
  logic [3:0] e_rel [2];
  logic [3:0] e_rep [2];
  logic [3:0] e_evt [2];
  logic       e_any [2];
  int         run_m [2][4];
  int         hold_m [2][4];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      sy1[d] = '0; sy2[d] = '0; e_lvl[d] = '0; e_prs[d] = '0; e_rel[d] = '0;
      e_rep[d] = '0; e_evt[d] = '0; e_any[d] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        run_m[d][k] = 0;
        hold_m[d][k] = 0;
      end
    end
  endtask

  // A level change is accepted once the synchronised key shows the new level
  // on DEB+1 consecutive edges; hold_m counts stable held edges since the press.
  task automatic model_step();
    logic [3:0] nk [2];
    logic [3:0] cl [2];
    if (rst) begin
      model_reset();
      return;
    end
    nk[0] = keys_hi; nk[1] = ~keys_lo;
    cl[0] = clr_hi;  cl[1] = clr_lo;
    for (int d = 0; d < 2; d++) begin
      e_evt[d] = (e_evt[d] & ~cl[d]) | e_prs[d];
      e_any[d] = |e_evt[d];
      e_prs[d] = '0; e_rel[d] = '0; e_rep[d] = '0;
      for (int k = 0; k < 4; k++) begin
        logic ks;
        ks = sy2[d][k];
        if (ks != e_lvl[d][k]) begin
          run_m[d][k]++;
          if (run_m[d][k] == int'(DEB) + 1) begin
            e_lvl[d][k] = ks;
            run_m[d][k] = 0;
            if (ks) begin
              e_prs[d][k] = 1'b1;
              hold_m[d][k] = 0;
            end else begin
              e_rel[d][k] = 1'b1;
            end
          end
        end else begin
          if (e_lvl[d][k] && run_m[d][k] == 0) begin
            hold_m[d][k]++;
`ifdef GAME_KEYS_REPEAT_EN
            if (hold_m[d][k] >= int'(RDLY) && (hold_m[d][k] - int'(RDLY)) % int'(RRATE) == 0)
              e_rep[d][k] = 1'b1;
`endif
          end
          run_m[d][k] = 0;
        end
      end
      sy2[d] = sy1[d];
      sy1[d] = nk[d];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("hi.level",   32'(hi_lvl), 32'(e_lvl[0]));
    check("hi.press",   32'(hi_prs), 32'(e_prs[0]));
    check("hi.release", 32'(hi_rel), 32'(e_rel[0]));
    check("hi.repeat",  32'(hi_rep), 32'(e_rep[0]));
    check("hi.evt",     32'(hi_evt), 32'(e_evt[0]));
    check("hi.any",     32'(hi_any), 32'(e_any[0]));
    check("lo.level",   32'(lo_lvl), 32'(e_lvl[1]));
    check("lo.press",   32'(lo_prs), 32'(e_prs[1]));
    check("lo.release", 32'(lo_rel), 32'(e_rel[1]));
    check("lo.repeat",  32'(lo_rep), 32'(e_rep[1]));
    check("lo.evt",     32'(lo_evt), 32'(e_evt[1]));
    check("lo.any",     32'(lo_any), 32'(e_any[1]));
  endtask

  // Inputs change only at the falling edge; the model follows each rising edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [31:0] rep_mask, rep_exp;

    rst = 1'b1; keys_hi = 4'h0; keys_lo = 4'hF; clr_hi = 4'h0; clr_lo = 4'h0;
    model_reset();
    ticks(3);
    check("reset.hi_level", 32'(hi_lvl), 32'd0);
    check("reset.lo_press", 32'(lo_prs), 32'd0);
    rst = 1'b0;
    ticks(2);

    // Reset in the middle of PCHK, then latency from the first sampling edge
    keys_hi[0] = 1'b1;
    ticks(4);
    rst = 1'b1;
    model_reset();
    ticks(2);
    check("rst_mid.level", 32'(hi_lvl), 32'd0);
    rst = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 12 && cyc == 0; i++) begin
      tick();
      if (hi_prs[0]) cyc = i;
    end
    check("lat.press0", 32'(cyc), 32'd7);
    check("lat.level0", 32'(hi_lvl[0]), 32'd1);
    ticks(1);
    check("lat.level0_hold", 32'(hi_lvl[0]), 32'd1);

    // Glitch on key 1: three cycles high
    keys_hi[1] = 1'b1;
    ticks(3);
    keys_hi[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (hi_prs[1] || hi_lvl[1]) seen = 1'b1;
    end
    check("glitch.seen", 32'(seen), 32'd0);
    check("glitch.evt1", 32'(hi_evt[1]), 32'd0);

    // Auto-repeat on key 2
    keys_hi[2] = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 12 && cyc == 0; i++) begin
      tick();
      if (hi_prs[2]) cyc = i;
    end
    check("rep.press2", 32'(cyc), 32'd7);
    rep_mask = '0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (hi_rep[2]) rep_mask[i] = 1'b1;
    end
`ifdef GAME_KEYS_REPEAT_EN
    rep_exp = (32'd1 << 10) | (32'd1 << 13) | (32'd1 << 16) | (32'd1 << 19) | (32'd1 << 22);
`else
    rep_exp = 32'd0;
`endif
    check("rep.offsets", rep_mask, rep_exp);
    keys_hi[2] = 1'b0;
    ticks(8);

    // Short dip on held key 0 gives no release, full release does
    keys_hi[0] = 1'b0;
    ticks(2);
    keys_hi[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (hi_rel[0] || !hi_lvl[0]) seen = 1'b1;
    end
    check("dip.release", 32'(seen), 32'd0);
    keys_hi[0] = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 12 && cyc == 0; i++) begin
      tick();
      if (hi_rel[0]) begin
        cyc = i;
        check("rel.level_falls", 32'(hi_lvl[0]), 32'd0);
      end
    end
    check("rel.latency", 32'(cyc), 32'd7);
    ticks(3);

    // Event register
    clr_hi = 4'hF;
    tick();
    clr_hi = 4'h0;
    keys_hi = 4'b1001;
    cyc = 0;
    for (int i = 1; i <= 12 && cyc == 0; i++) begin
      tick();
      if (hi_prs[0]) cyc = i;
    end
    check("evt.press_both", 32'(hi_prs), 32'b1001);
    tick();
    check("evt.reg", 32'(hi_evt), 32'b1001);
    check("evt.any", 32'(hi_any), 32'd1);
    keys_hi = 4'h0;
    ticks(10);
    keys_hi[0] = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      tick();
      if (e_prs[0][0]) seen = 1'b1;
    end
    check("evt.repress_seen", 32'(seen), 32'd1);
    clr_hi = 4'b0001;
    tick();
    clr_hi = 4'h0;
    check("evt.set_wins", 32'(hi_evt[0]), 32'd1);
    clr_hi = 4'b1001;
    tick();
    clr_hi = 4'h0;
    check("evt.cleared", 32'(hi_evt), 32'd0);
    check("evt.any_clr", 32'(hi_any), 32'd0);
    keys_hi = 4'h0;
    ticks(8);

    // Active-low instance
    keys_lo[1] = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 12 && cyc == 0; i++) begin
      tick();
      if (lo_prs[1]) cyc = i;
    end
    check("pol.press1", 32'(cyc), 32'd7);
    keys_lo[1] = 1'b1;
    ticks(8);

    // Randomised phase with long-ish holds, occasional clears and one reset
    for (int c = 0; c < 700; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 9) == 0) keys_hi[k] = ~keys_hi[k];
        if ($urandom_range(0, 9) == 0) keys_lo[k] = ~keys_lo[k];
      end
      clr_hi = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      clr_lo = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      if (c == 350) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
    end
    rst = 1'b0;
    clr_hi = 4'h0;
    clr_lo = 4'h0;
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_keys_ctrl.md
# game_keys_ctrl

Parametrised key conditioner for the CPU-based game wrappers. Takes the raw board keys, synchronises and debounces each one, and produces clean level, press, release and optional auto-repeat strobes. It also provides a sticky press-event register the game CPU polls and clears. It sits between the board key pins and the game core (`left`/`right` and future inputs), replacing the direct key-to-core connection.

## Interface
Parameters:
- `KEYS_N`, 4: number of key channels.
- `ACT_LVL`, 1: raw level meaning "pressed" (1 = active-high, 0 = active-low).
- `DEB_CYC`, 50000: stable cycles required to accept a transition; must be ≥ 2.
- `CNT_W`, 16: width of the debounce and repeat counters; must hold `DEB_CYC`, `REP_DELAY` and `REP_RATE`.
- `REP_DELAY`, 25000: cycles held after a press before the first repeat strobe.
- `REP_RATE`, 5000: cycles between subsequent repeat strobes; must be ≥ 1.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `keys` in `KEYS_N`: raw asynchronous key inputs.
- `key_level` out `KEYS_N`: debounced pressed state.
- `key_press` out `KEYS_N`: one-cycle strobe on an accepted press.
- `key_release` out `KEYS_N`: one-cycle strobe on an accepted release.
- `key_repeat` out `KEYS_N`: one-cycle auto-repeat strobe.
- `evt_clr` in `KEYS_N`: per-key clear of the event register; one-cycle pulse.
- `evt_press` out `KEYS_N`: sticky press-event register.
- `evt_any` out 1: OR of `evt_press`.

## Operation
- Per key, the raw input is normalised to pressed = 1 (XOR with `~ACT_LVL`), then passed through a 2-flop synchroniser, giving `ksync`.
- Each key has an independent FSM with a debounce counter `dcnt` and a repeat counter `rcnt`.
  - **IDLE** (level 0): `ksync` = 1 → **PCHK**, `dcnt` = 0.
  - **PCHK**:
    - `ksync` = 0 → **IDLE**.
    - Otherwise `dcnt` increments. When `dcnt` = `DEB_CYC`−1 → **HELD**, level = 1, `key_press` pulses, `rcnt` = 0.
  - **HELD**:
    - `ksync` = 0 → **RCHK**, `dcnt` = 0.
    - Otherwise `rcnt` increments (repeat only, see Configuration).
  - **RCHK**:
    - `ksync` = 1 → **HELD**; `rcnt` is preserved (frozen during RCHK).
    - Otherwise `dcnt` increments. When `dcnt` = `DEB_CYC`−1 → **IDLE**, level = 0, `key_release` pulses.
- Repeat rule, in HELD with `ksync` = 1:
  - The first repeat strobe fires when `rcnt` = `REP_DELAY`−1.
  - Thereafter `rcnt` reloads to `REP_DELAY`−`REP_RATE` and fires again each time it reaches `REP_DELAY`−1.
  - Net effect: one strobe every `REP_RATE` cycles.
- The press strobe is never accompanied by a repeat strobe in the same cycle.
- Event register: `evt_press[i]` sets on `key_press[i]` and clears on `evt_clr[i]`.
  - Set and clear in the same cycle: set wins.
  - Clear on a bit that is already 0: no effect.
- Channels are fully independent. Simultaneous events on different keys are all reported in the same cycle.
- Counters saturate logic is not needed: the FSM leaves the counting state before overflow.

## Timing
- Reset values: every FSM in IDLE, synchroniser flops 0, counters 0, and all outputs 0.
- Reset mid-operation: immediate return to the reset state; no strobe is emitted on reset release.
- All outputs are registered.
- Press latency: raw pressed level first sampled at edge N and held stable → `key_press` and `key_level` high after edge N+`DEB_CYC`+2.
- Release latency: same, `DEB_CYC`+2 cycles.
- Glitch rejection: any raw pulse shorter than `DEB_CYC` cycles (after synchronisation) produces no strobe and no level change.
- First repeat strobe fires `REP_DELAY` cycles after `key_press`; subsequent strobes every `REP_RATE` cycles.
- `evt_press` rises the cycle after `key_press` (registered from the strobe). `evt_any` rises the same cycle as `evt_press`.
- `evt_clr` takes effect at the next edge.

## Configuration
- `GAME_KEYS_REPEAT_EN` defined: `rcnt` and the repeat logic are compiled in, and `key_repeat` behaves as above.
- Not defined: `rcnt` is removed and `key_repeat` is tied to 0. `REP_DELAY` and `REP_RATE` are ignored. All other behaviour is identical.

## Test plan
All scenarios use `KEYS_N`=4, `DEB_CYC`=4, `REP_DELAY`=10, `REP_RATE`=3, `ACT_LVL`=1.
- Reset/latency: assert `reset` mid-PCHK, then release, then hold `keys[0]`=1 from edge N → no strobe during reset; `key_press[0]` one cycle after edge N+6; `key_level[0]`=1 from then on.
- Glitch: drive `keys[1]` high for 3 cycles, then low → `key_press`, `key_level` and `evt_press` stay 0.
- Release: release `keys[0]` after a press → one `key_release[0]` strobe after 6 cycles; `key_level[0]` falls the same cycle; a 2-cycle low dip in HELD gives no release.
- Repeat (macro defined): hold `keys[2]` for 25 cycles after press → `key_repeat[2]` at +10, +13, +16, +19, +22. With the macro undefined → `key_repeat` stays 0.
- Events: press keys 0 and 3 in the same cycle → `evt_press`=4'b1001 and `evt_any`=1. Pulse `evt_clr`=4'b0001 in the same cycle as a new `key_press[0]` → bit 0 stays 1. Then `evt_clr`=4'b1001 → `evt_press`=0 and `evt_any`=0.
- Polarity: with `ACT_LVL`=0 and `keys` idle at 4'hF, driving `keys[1]`=0 → `key_press[1]` after 6 cycles; no strobes out of reset.
